// File: rtl/dtcore32_mem_pkg.sv
// Shared types for the dtcore32 unified-memory arbiter: FSM state, transaction owner
// and default bus widths.
package dtcore32_mem_pkg;

  localparam int unsigned DEFAULT_ADDR_W = 32;
  localparam int unsigned DEFAULT_DATA_W = 32;

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StData
  } arb_state_e;

  typedef enum logic [1:0] {
    OwnerNone,
    OwnerFetch,
    OwnerData
  } owner_e;

endpackage

// File: rtl/dtcore32_arb_pick.sv
// Combinational winner select: data first, unless fetch is waiting and the data streak
// has reached its limit.
module dtcore32_arb_pick
  import dtcore32_mem_pkg::*;
(
  input  logic   i_req,
  input  logic   d_req,
  input  logic   streak_full,
  output owner_e winner
);

  always_comb begin
    winner = OwnerNone;
    if (d_req && !(i_req && streak_full)) begin
      winner = OwnerData;
    end else if (i_req) begin
      winner = OwnerFetch;
    end
  end

endmodule

// File: rtl/dtcore32_mem_arbiter.sv
// Shares one single-port memory between the dtcore32 fetch and data ports, one transaction
// outstanding at a time. Define DTCORE32_ARB_TIMEOUT_EN to add an rvalid watchdog.
module dtcore32_mem_arbiter
  import dtcore32_mem_pkg::*;
#(
  parameter int unsigned ADDR_W         = DEFAULT_ADDR_W,
  parameter int unsigned DATA_W         = DEFAULT_DATA_W,
  parameter int unsigned MAX_D_STREAK   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,

  input  logic                i_req_i,
  input  logic [ADDR_W-1:0]   i_addr_i,
  output logic                i_gnt_o,
  output logic                i_rvalid_o,
  output logic [DATA_W-1:0]   i_rdata_o,
  output logic                i_err_o,

  input  logic                d_req_i,
  input  logic [ADDR_W-1:0]   d_addr_i,
  input  logic [DATA_W/8-1:0] d_wmask_i,
  input  logic [DATA_W-1:0]   d_wdata_i,
  output logic                d_gnt_o,
  output logic                d_rvalid_o,
  output logic [DATA_W-1:0]   d_rdata_o,
  output logic                d_err_o,

  output logic                m_req_o,
  output logic [ADDR_W-1:0]   m_addr_o,
  output logic [DATA_W/8-1:0] m_wmask_o,
  output logic [DATA_W-1:0]   m_wdata_o,
  input  logic                m_gnt_i,
  input  logic                m_rvalid_i,
  input  logic [DATA_W-1:0]   m_rdata_i
);

  localparam int unsigned MaskW   = DATA_W / 8;
  localparam int unsigned StreakW = $clog2(MAX_D_STREAK + 1);

  arb_state_e          state_q, state_d;
  owner_e              owner_q, owner_d;
  owner_e              winner;
  logic [StreakW-1:0]  streak_q, streak_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [MaskW-1:0]    wmask_q, wmask_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;

  logic arb_en;
  logic streak_full;
  logic in_addr;
  logic in_data;
  logic fetch_gnt;
  logic data_gnt;
  logic rsp;
  logic timeout;

  assign in_addr     = (state_q == StAddr);
  assign in_data     = (state_q == StData);
  assign streak_full = (streak_q == StreakW'(MAX_D_STREAK));

  dtcore32_arb_pick u_pick (
    .i_req       (i_req_i),
    .d_req       (d_req_i),
    .streak_full (streak_full),
    .winner      (winner)
  );

`ifdef DTCORE32_ARB_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);

  logic [WdW-1:0] wd_q;

  // Counts DATA cycles of the current transaction; leaving DATA always passes through
  // ADDR or IDLE, which clears it for the next entry.
  always_ff @(posedge clk_i) begin
    if (rst_i || !in_data) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_q + 1'b1;
    end
  end

  assign timeout = in_data && !m_rvalid_i && (wd_q == WdW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout            = 1'b0;
`endif

  // State and request registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      owner_q  <= OwnerNone;
      streak_q <= '0;
      addr_q   <= '0;
      wmask_q  <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      streak_q <= streak_d;
      addr_q   <= addr_d;
      wmask_q  <= wmask_d;
      wdata_q  <= wdata_d;
    end
  end

  // Next-state: arbitration happens in IDLE and on the completing cycle of DATA.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    wmask_d = wmask_q;
    wdata_d = wdata_q;
    arb_en  = 1'b0;

    case (state_q)
      StIdle: arb_en = 1'b1;
      StAddr: begin
        if (m_gnt_i) begin
          state_d = StData;
        end
      end
      StData: begin
        if (m_rvalid_i) begin
          arb_en = 1'b1;
        end else if (timeout) begin
          state_d = StIdle;
          owner_d = OwnerNone;
        end
      end
      default: begin
        state_d = StIdle;
        owner_d = OwnerNone;
      end
    endcase

    if (arb_en) begin
      owner_d = winner;
      state_d = (winner == OwnerNone) ? StIdle : StAddr;
      if (winner == OwnerData) begin
        addr_d  = d_addr_i;
        wmask_d = d_wmask_i;
        wdata_d = d_wdata_i;
      end else if (winner == OwnerFetch) begin
        addr_d  = i_addr_i;
        wmask_d = '0;
        wdata_d = '0;
      end
    end

    // The streak only matters while fetch is actually waiting.
    streak_d = streak_q;
    if (!i_req_i || fetch_gnt) begin
      streak_d = '0;
    end else if (data_gnt && !streak_full) begin
      streak_d = streak_q + 1'b1;
    end
  end

  // Outputs: grants and responses are steered combinationally to the current owner.
  always_comb begin
    fetch_gnt  = in_addr && m_gnt_i && (owner_q == OwnerFetch);
    data_gnt   = in_addr && m_gnt_i && (owner_q == OwnerData);
    rsp        = in_data && (m_rvalid_i || timeout);

    m_req_o    = in_addr;
    m_addr_o   = addr_q;
    m_wmask_o  = wmask_q;
    m_wdata_o  = wdata_q;

    i_gnt_o    = fetch_gnt;
    d_gnt_o    = data_gnt;
    i_rvalid_o = rsp && (owner_q == OwnerFetch);
    d_rvalid_o = rsp && (owner_q == OwnerData);
    i_err_o    = i_rvalid_o && timeout;
    d_err_o    = d_rvalid_o && timeout;
    i_rdata_o  = (i_rvalid_o && !timeout) ? m_rdata_i : '0;
    // Writes acknowledge with zero data.
    d_rdata_o  = (d_rvalid_o && !timeout && (wmask_q == '0)) ? m_rdata_i : '0;
  end

endmodule

// File: tb/tb_dtcore32_mem_arbiter.sv
// Self-checking bench for dtcore32_mem_arbiter: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a transaction model.
module tb_dtcore32_mem_arbiter;

  localparam int unsigned MAXS = 4;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        i_req_i, i_gnt_o, i_rvalid_o, i_err_o;
  logic [31:0] i_addr_i, i_rdata_o;
  logic        d_req_i, d_gnt_o, d_rvalid_o, d_err_o;
  logic [31:0] d_addr_i, d_wdata_i, d_rdata_o;
  logic [3:0]  d_wmask_i;
  logic        m_req_o, m_gnt_i, m_rvalid_i;
  logic [31:0] m_addr_o, m_wdata_o, m_rdata_i;
  logic [3:0]  m_wmask_o;

  always #5 clk = ~clk;

  dtcore32_mem_arbiter #(
    .ADDR_W         (32),
    .DATA_W         (32),
    .MAX_D_STREAK   (MAXS),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .i_req_i    (i_req_i),
    .i_addr_i   (i_addr_i),
    .i_gnt_o    (i_gnt_o),
    .i_rvalid_o (i_rvalid_o),
    .i_rdata_o  (i_rdata_o),
    .i_err_o    (i_err_o),
    .d_req_i    (d_req_i),
    .d_addr_i   (d_addr_i),
    .d_wmask_i  (d_wmask_i),
    .d_wdata_i  (d_wdata_i),
    .d_gnt_o    (d_gnt_o),
    .d_rvalid_o (d_rvalid_o),
    .d_rdata_o  (d_rdata_o),
    .d_err_o    (d_err_o),
    .m_req_o    (m_req_o),
    .m_addr_o   (m_addr_o),
    .m_wmask_o  (m_wmask_o),
    .m_wdata_o  (m_wdata_o),
    .m_gnt_i    (m_gnt_i),
    .m_rvalid_i (m_rvalid_i),
    .m_rdata_i  (m_rdata_i)
  );

  int total = 0;
  int bad   = 0;

  // Transaction-level model: an open transaction, whether memory has accepted it yet,
  // its request fields, and the number of data grants fetch has been waiting through.
  bit          mb_busy    = 1'b0;
  bit          mb_granted = 1'b0;
  bit          mb_fetch   = 1'b0;
  logic [31:0] mb_addr    = '0;
  logic [31:0] mb_wdata   = '0;
  logic [3:0]  mb_wmask   = '0;
  int          mb_streak  = 0;
  bit          last_i_gnt = 1'b0;
  bit          last_d_gnt = 1'b0;
  int          n_fetch_done = 0;
  int          n_data_done  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic        e_mreq, e_ig, e_dg, e_iv, e_dv;
    logic [31:0] e_ird, e_drd;
    bit          can_pick;
    e_mreq = mb_busy && !mb_granted;
    e_ig   = e_mreq && m_gnt_i && mb_fetch;
    e_dg   = e_mreq && m_gnt_i && !mb_fetch;
    e_iv   = mb_busy && mb_granted && m_rvalid_i && mb_fetch;
    e_dv   = mb_busy && mb_granted && m_rvalid_i && !mb_fetch;
    e_ird  = e_iv ? m_rdata_i : 32'h0;
    e_drd  = (e_dv && mb_wmask == 4'h0) ? m_rdata_i : 32'h0;

    chk("m_req", m_req_o, e_mreq);
    chk("m_addr", m_addr_o, mb_addr);
    chk("m_wmask", m_wmask_o, mb_wmask);
    chk("m_wdata", m_wdata_o, mb_wdata);
    chk("i_gnt", i_gnt_o, e_ig);
    chk("d_gnt", d_gnt_o, e_dg);
    chk("i_rvalid", i_rvalid_o, e_iv);
    chk("d_rvalid", d_rvalid_o, e_dv);
    chk("i_rdata", i_rdata_o, e_ird);
    chk("d_rdata", d_rdata_o, e_drd);
    chk("i_err", i_err_o, 1'b0);
    chk("d_err", d_err_o, 1'b0);

    last_i_gnt = e_ig;
    last_d_gnt = e_dg;
    if (e_iv) n_fetch_done++;
    if (e_dv) n_data_done++;

    if (rst_i) begin
      mb_busy    = 1'b0;
      mb_granted = 1'b0;
      mb_fetch   = 1'b0;
      mb_addr    = '0;
      mb_wmask   = '0;
      mb_wdata   = '0;
      mb_streak  = 0;
    end else begin
      can_pick = !mb_busy || (mb_granted && m_rvalid_i);
      if (mb_busy && !mb_granted && m_gnt_i) mb_granted = 1'b1;
      else if (mb_busy && mb_granted && m_rvalid_i) mb_busy = 1'b0;
      if (can_pick) begin
        if (d_req_i && !(i_req_i && mb_streak == MAXS)) begin
          mb_busy = 1'b1; mb_granted = 1'b0; mb_fetch = 1'b0;
          mb_addr = d_addr_i; mb_wmask = d_wmask_i; mb_wdata = d_wdata_i;
        end else if (i_req_i) begin
          mb_busy = 1'b1; mb_granted = 1'b0; mb_fetch = 1'b1;
          mb_addr = i_addr_i; mb_wmask = '0; mb_wdata = '0;
        end
      end
      if (!i_req_i || e_ig) mb_streak = 0;
      else if (e_dg && mb_streak < MAXS) mb_streak++;
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
  endtask

  task automatic idle_inputs();
    i_req_i = 0; i_addr_i = '0;
    d_req_i = 0; d_addr_i = '0; d_wmask_i = '0; d_wdata_i = '0;
    m_gnt_i = 0; m_rvalid_i = 0; m_rdata_i = '0;
  endtask

  task automatic do_reset();
    adv();
    idle_inputs();
    rst_i = 1;
    tick();
  endtask

  int seq[$];

  initial begin
    rst_i = 1;
    idle_inputs();
    repeat (3) begin
      adv();
      tick();
    end
    chk("rst_mreq", m_req_o, 0);
    chk("rst_maddr", m_addr_o, 0);
    chk("rst_igvalid", {i_gnt_o, i_rvalid_o, d_gnt_o, d_rvalid_o}, 0);

    // Fetch only.
    adv(); rst_i = 0; i_req_i = 1; i_addr_i = 32'h100; tick();
    chk("f_idle_mreq", m_req_o, 0);
    adv(); m_gnt_i = 1; tick();
    chk("f_mreq", m_req_o, 1);
    chk("f_addr", m_addr_o, 32'h100);
    chk("f_wmask", m_wmask_o, 0);
    chk("f_ignt", i_gnt_o, 1);
    chk("f_dgnt", d_gnt_o, 0);
    adv(); i_req_i = 0; m_gnt_i = 0; m_rvalid_i = 1; m_rdata_i = 32'h13; tick();
    chk("f_irvalid", i_rvalid_o, 1);
    chk("f_irdata", i_rdata_o, 32'h13);
    chk("f_drvalid", d_rvalid_o, 0);
    chk("f_drdata", d_rdata_o, 0);
    adv(); m_rvalid_i = 0; tick();
    chk("f_done_mreq", m_req_o, 0);

    // Simultaneous requests: data first, fetch back-to-back.
    do_reset();
    adv(); rst_i = 0;
    i_req_i = 1; i_addr_i = 32'h300;
    d_req_i = 1; d_addr_i = 32'h200; d_wmask_i = 4'hF; d_wdata_i = 32'hDEADBEEF;
    tick();
    adv(); m_gnt_i = 1; tick();
    chk("s_addr", m_addr_o, 32'h200);
    chk("s_wmask", m_wmask_o, 4'hF);
    chk("s_wdata", m_wdata_o, 32'hDEADBEEF);
    chk("s_dgnt", d_gnt_o, 1);
    chk("s_ignt", i_gnt_o, 0);
    adv(); d_req_i = 0; m_gnt_i = 0; m_rvalid_i = 1; m_rdata_i = 32'h55; tick();
    chk("s_drvalid", d_rvalid_o, 1);
    chk("s_drdata_wr", d_rdata_o, 0);
    chk("s_irvalid", i_rvalid_o, 0);
    adv(); m_rvalid_i = 0; m_gnt_i = 1; tick();
    chk("s_b2b_mreq", m_req_o, 1);
    chk("s_b2b_addr", m_addr_o, 32'h300);
    chk("s_b2b_wmask", m_wmask_o, 0);
    chk("s_b2b_ignt", i_gnt_o, 1);
    adv(); i_req_i = 0; m_gnt_i = 0; m_rvalid_i = 1; m_rdata_i = 32'hABCD; tick();
    chk("s_irvalid2", i_rvalid_o, 1);
    chk("s_irdata2", i_rdata_o, 32'hABCD);
    adv(); m_rvalid_i = 0; tick();

    // Starvation limit with zero-wait memory: 4 data grants, then fetch, repeating.
    do_reset();
    adv(); rst_i = 0;
    i_req_i = 1; i_addr_i = 32'h40;
    d_req_i = 1; d_addr_i = 32'h80; d_wmask_i = 4'h0;
    m_gnt_i = 1; m_rvalid_i = 1; m_rdata_i = 32'h77;
    tick();
    for (int c = 0; c < 30; c++) begin
      adv();
      tick();
      if (d_gnt_o) seq.push_back(0);
      if (i_gnt_o) seq.push_back(1);
    end
    chk("starve_count", seq.size() >= 10, 1);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("starve_grant%0d", k), seq[k], (k % 5 == 4) ? 1 : 0);
    end

    // Grant stall: request held stable, no grants while memory withholds m_gnt_i.
    do_reset();
    adv(); rst_i = 0;
    d_req_i = 1; d_addr_i = 32'h440; d_wmask_i = 4'h3; d_wdata_i = 32'h12345678;
    tick();
    adv(); i_req_i = 1; i_addr_i = 32'h500; tick();
    for (int c = 0; c < 5; c++) begin
      if (c > 0) begin
        adv();
        tick();
      end
      chk("stall_mreq", m_req_o, 1);
      chk("stall_addr", m_addr_o, 32'h440);
      chk("stall_wdata", m_wdata_o, 32'h12345678);
      chk("stall_gnts", {i_gnt_o, d_gnt_o}, 0);
    end
    adv(); m_gnt_i = 1; tick();
    chk("stall_dgnt", d_gnt_o, 1);

    // Reset while in DATA, then a stray response.
    adv(); d_req_i = 0; i_req_i = 0; m_gnt_i = 0; rst_i = 1; tick();
    adv(); rst_i = 0; m_rvalid_i = 1; m_rdata_i = 32'hFFFF; tick();
    chk("rm_drvalid", d_rvalid_o, 0);
    chk("rm_irvalid", i_rvalid_o, 0);
    chk("rm_mreq", m_req_o, 0);
    chk("rm_addr", m_addr_o, 0);
    chk("rm_wdata", m_wdata_o, 0);
    chk("rm_drdata", d_rdata_o, 0);
    adv(); m_rvalid_i = 0; tick();

    // Randomized traffic; requesters hold their request until granted.
    n_fetch_done = 0;
    n_data_done  = 0;
    for (int c = 0; c < 4000; c++) begin
      adv();
      rst_i = ($urandom_range(0, 299) == 0);
      if (i_req_i) begin
        if (last_i_gnt) begin
          if ($urandom_range(0, 1) == 1) i_addr_i = $urandom;
          else i_req_i = 0;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        i_req_i = 1; i_addr_i = $urandom;
      end
      if (d_req_i) begin
        if (last_d_gnt) begin
          if ($urandom_range(0, 3) != 0) begin
            d_addr_i  = $urandom;
            d_wmask_i = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15));
            d_wdata_i = $urandom;
          end else begin
            d_req_i = 0;
          end
        end
      end else if ($urandom_range(0, 1) == 0) begin
        d_req_i   = 1;
        d_addr_i  = $urandom;
        d_wmask_i = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15));
        d_wdata_i = $urandom;
      end
      m_gnt_i    = ($urandom_range(0, 2) != 0);
      m_rvalid_i = ($urandom_range(0, 1) == 1);
      m_rdata_i  = $urandom;
      tick();
    end
    chk("rand_fetch_seen", n_fetch_done > 0, 1);
    chk("rand_data_seen", n_data_done > 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
